// File: rtl/seq_div32.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock through a
// single (WIDTH+1)-bit subtract step, with a start/done handshake.
module seq_div32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] q_reg, d_reg;
  logic [WIDTH:0]   r_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_sh, t, r_next;
  logic [WIDTH-1:0] q_next;
  logic             last_iter;

  // r_reg stays below d_reg, so its top bit is always zero before the shift.
  always_comb begin
    r_sh      = (r_reg << 1) | {{WIDTH{1'b0}}, q_reg[WIDTH-1]};
    t         = r_sh - {1'b0, d_reg};
    r_next    = t[WIDTH] ? r_sh : t;
    q_next    = {q_reg[WIDTH-2:0], ~t[WIDTH]};
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          done <= 1'b0;
          if (start) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            cnt   <= '0;
            if (divisor == '0) begin
              // Zero divisor skips the iterations and reports immediately.
              state       <= FIN;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= RUN;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          q_reg <= q_next;
          r_reg <= r_next;
          if (cnt != CW'(WIDTH)) cnt <= cnt + 1'b1;
          if (last_iter) begin
            state     <= FIN;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div32.sv
// Directed and random checks of seq_div32 against a / and % reference model,
// with expected results queued at start and compared at done.
module tb_seq_div32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  seq_div32 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one start cycle and queues the expected result.
  task automatic go(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.dz  = (b == 0);
    e.q   = (b == 0) ? 32'hFFFF_FFFF : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.lat = (b == 0) ? 1 : 33;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // n0 = edges already elapsed since the start edge (inclusive).
  task automatic wait_done(input int n0, input logic [31:0] a, input logic [31:0] b);
    int   n;
    int   bc;
    exp_t e;
    n  = n0;
    bc = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
    chk("sb_size", 64'(sb.size()), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("latency", 64'(n), 64'(e.lat));
    chk("busy_cycles", 64'(bc), 64'(e.lat - n0));
    chk("quotient", 64'(quotient), 64'(e.q));
    chk("remainder", 64'(remainder), 64'(e.r));
    chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
    chk("busy_at_done", 64'(busy), 64'd0);
    if (b != 0) begin
      chk("invariant", 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
      chk("rem_lt_div", 64'(remainder < b), 64'd1);
    end
  endtask

  initial begin
    int ndone;
    logic [31:0] a, b;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 100 / 7
    go(32'd100, 32'd7);
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_done(1, 32'd100, 32'd7);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("hold_quotient", 64'(quotient), 64'd14);
    chk("hold_remainder", 64'(remainder), 64'd2);

    // Max / 1, then back-to-back max / max from FIN
    go(32'hFFFF_FFFF, 32'd1);
    wait_done(1, 32'hFFFF_FFFF, 32'd1);
    go(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);

    // divisor > dividend, then divide by zero, then dz clears on next start
    go(32'd3, 32'd10);
    wait_done(1, 32'd3, 32'd10);
    @(negedge clk);
    go(32'd5, 32'd0);
    wait_done(1, 32'd5, 32'd0);
    @(negedge clk);
    chk("dz_held", 64'(div_by_zero), 64'd1);
    go(32'd0, 32'd3);
    chk("dz_cleared_on_start", 64'(div_by_zero), 64'd0);
    wait_done(1, 32'd0, 32'd3);
    @(negedge clk);

    // Start while busy is ignored
    go(32'd1000, 32'd9);
    repeat (10) @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(12, 32'd1000, 32'd9);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("no_extra_done", 64'(ndone), 64'd0);

    // Reset mid-operation discards the run
    go(32'd1000, 32'd9);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_quotient", 64'(quotient), 64'd0);
    chk("mid_rst_remainder", 64'(remainder), 64'd0);
    chk("mid_rst_dz", 64'(div_by_zero), 64'd0);
    go(32'd81, 32'd9);
    wait_done(1, 32'd81, 32'd9);
    @(negedge clk);

    // Random nonzero divisors, issued back-to-back from FIN
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom_range(255, 1);
        1: b = $urandom | 32'h1;
        2: b = (a == 0) ? 32'd1 : a + $urandom_range(3, 0);
        default: b = $urandom >> $urandom_range(31, 0);
      endcase
      if (b == 0) b = 32'd1;
      go(a, b);
      wait_done(1, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
